// File: rtl/serial_add_sub_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state encoding
// and the iteration-counter width helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // A 2-bit operand still needs a 1-bit counter, so the width never drops to zero.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/response bundle for serial_add_sub: operands and start in, status and
// result out.
interface serial_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, carry_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, carry_out, overflow
    );
endinterface

// File: rtl/serial_add_sub_carry_cell.sv
// Combinational full-adder cell: 3-input XOR sum and majority carry. Shared by the
// serial arithmetic blocks.
module carry_cell (
    input  logic ci,
    input  logic x,
    input  logic y,
    output logic s,
    output logic co
);
    assign s  = ci ^ x ^ y;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial two's-complement adder/subtractor: one bit per clock, LSB first.
// A single carry flop feeds a combinational full-adder cell.
module serial_add_sub
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_add_sub_if.slave   bus
);
    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           r_state;
    state_e           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [WIDTH-1:0] r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_overflow;
    logic             r_busy;
    logic             r_done;
    logic             w_load;
    logic             w_last;
    logic             w_s;
    logic             w_c;

    carry_cell u_carry_cell (
        .ci (r_carry),
        .x  (r_a_sh[0]),
        .y  (r_b_sh[0]),
        .s  (w_s),
        .co (w_c)
    );

    // NOTE: every signal gets a default before the case so no path leaves a latch.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_last = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_load = 1'b1;
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                w_load = bus.start;
                w_next = bus.start ? SHIFT : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == SHIFT);
            r_done  <= (w_next == DONE);
        end
    end

    // Sum bits collect in r_res_sh; r_result only changes on load (clear) and the
    // final shift, so the visible result never shows partial sums.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res_sh    <= '0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_load) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.sub ? ~bus.b : bus.b;
            r_carry  <= bus.sub;
            r_cnt    <= '0;
            r_res_sh <= '0;
            r_result <= '0;
        end else if (r_state == SHIFT) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_res_sh <= {w_s, r_res_sh[WIDTH-1:1]};
            r_carry  <= w_c;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_result    <= {w_s, r_res_sh[WIDTH-1:1]};
                r_carry_out <= w_c;
                // Carry into the MSB differs from carry out of it: signed overflow.
                r_overflow  <= w_c ^ r_carry;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): directed cases, ignored
// start, mid-operation reset and random back-to-back with a scoreboard queue.
module tb_serial_add_sub;
    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             co;
        logic             ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    serial_add_sub_if #(.WIDTH(WIDTH)) bus ();

    serial_add_sub #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        exp_t       m;
        logic [8:0] s;
        logic [7:0] bb;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
        m.result = s[7:0];
        m.co     = s[8];
        m.ov     = sub ? ((a[7] != b[7]) && (s[7] != a[7]))
                       : ((a[7] == b[7]) && (s[7] != a[7]));
        return m;
    endfunction

    task automatic drive_start(input logic [7:0] a, input logic [7:0] b, input logic sub);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.sub   = sub;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done); else n_pass++;
        n_total++; if (bus.result !== 8'h00) $display("FAIL reset_result got=%h want=00", bus.result); else n_pass++;
        n_total++; if (bus.carry_out !== 1'b0) $display("FAIL reset_carry got=%b want=0", bus.carry_out); else n_pass++;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got=%b want=0", bus.overflow); else n_pass++;
    endtask

    task automatic test_directed();
        logic [7:0] ta [4] = '{8'hFF, 8'h7F, 8'h05, 8'h80};
        logic [7:0] tb [4] = '{8'h01, 8'h01, 8'h07, 8'h01};
        logic       ts [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] er [4] = '{8'h00, 8'h80, 8'hFE, 8'h7F};
        logic       ec [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       eo [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp_t e;
        int   lat;
        int   busy_cnt;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_start(ta[i], tb[i], ts[i]);
            sb_q.push_back('{result: er[i], co: ec[i], ov: eo[i]});
            lat      = 0;
            busy_cnt = 0;
            while (lat < 30) begin
                @(negedge clk);
                lat++;
                bus.start = 1'b0;
                if (bus.busy) busy_cnt++;
                if (bus.done) break;
            end
            n_total++; if (lat !== 9) $display("FAIL dir%0d_latency got=%0d want=9", i, lat); else n_pass++;
            n_total++; if (busy_cnt !== 8) $display("FAIL dir%0d_busy_cycles got=%0d want=8", i, busy_cnt); else n_pass++;
            e = sb_q.pop_front();
            n_total++; if (bus.result !== e.result) $display("FAIL dir%0d_result got=%h want=%h", i, bus.result, e.result); else n_pass++;
            n_total++; if (bus.carry_out !== e.co) $display("FAIL dir%0d_carry got=%b want=%b", i, bus.carry_out, e.co); else n_pass++;
            n_total++; if (bus.overflow !== e.ov) $display("FAIL dir%0d_ovf got=%b want=%b", i, bus.overflow, e.ov); else n_pass++;
            @(negedge clk);
            n_total++; if (bus.done !== 1'b0) $display("FAIL dir%0d_done_pulse got=%b want=0", i, bus.done); else n_pass++;
            n_total++; if (bus.result !== e.result) $display("FAIL dir%0d_result_hold got=%h want=%h", i, bus.result, e.result); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   lat;
        int   dones;
        @(negedge clk);
        drive_start(8'h55, 8'h11, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        n_total++; if (bus.busy !== 1'b1) $display("FAIL rstmid_busy_before got=%b want=1", bus.busy); else n_pass++;
        n_total++; if (bus.carry_out !== 1'b1) $display("FAIL rstmid_carry_before got=%b want=1", bus.carry_out); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", bus.busy); else n_pass++;
        n_total++; if (bus.done !== 1'b0) $display("FAIL rstmid_done got=%b want=0", bus.done); else n_pass++;
        n_total++; if (bus.result !== 8'h00) $display("FAIL rstmid_result got=%h want=00", bus.result); else n_pass++;
        n_total++; if (bus.carry_out !== 1'b0) $display("FAIL rstmid_carry got=%b want=0", bus.carry_out); else n_pass++;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL rstmid_ovf got=%b want=0", bus.overflow); else n_pass++;
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        n_total++; if (dones !== 0) $display("FAIL rstmid_no_done got=%0d want=0", dones); else n_pass++;
        drive_start(8'h03, 8'h04, 1'b0);
        sb_q.push_back('{result: 8'h07, co: 1'b0, ov: 1'b0});
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            bus.start = 1'b0;
            if (bus.done) break;
        end
        n_total++; if (lat !== 9) $display("FAIL rstmid_latency got=%0d want=9", lat); else n_pass++;
        e = sb_q.pop_front();
        n_total++; if (bus.result !== e.result) $display("FAIL rstmid_result_after got=%h want=%h", bus.result, e.result); else n_pass++;
        n_total++; if ({bus.carry_out, bus.overflow} !== {e.co, e.ov}) $display("FAIL rstmid_flags got=%b%b want=%b%b", bus.carry_out, bus.overflow, e.co, e.ov); else n_pass++;
    endtask

    task automatic test_ignore_start();
        exp_t       e;
        int         dones;
        int         first_lat;
        logic [7:0] res_at_done;
        @(negedge clk);
        drive_start(8'h10, 8'h20, 1'b0);
        sb_q.push_back('{result: 8'h30, co: 1'b0, ov: 1'b0});
        dones       = 0;
        first_lat   = -1;
        res_at_done = '0;
        for (int lat = 1; lat <= 25; lat++) begin
            @(negedge clk);
            if (bus.done) begin
                dones++;
                if (first_lat < 0) begin
                    first_lat   = lat;
                    res_at_done = bus.result;
                end
            end
            if (lat == 3) drive_start(8'hAA, 8'h55, 1'b1);
            else bus.start = 1'b0;
        end
        e = sb_q.pop_front();
        n_total++; if (dones !== 1) $display("FAIL ignore_done_count got=%0d want=1", dones); else n_pass++;
        n_total++; if (first_lat !== 9) $display("FAIL ignore_latency got=%0d want=9", first_lat); else n_pass++;
        n_total++; if (res_at_done !== e.result) $display("FAIL ignore_result got=%h want=%h", res_at_done, e.result); else n_pass++;
        n_total++; if (bus.result !== e.result) $display("FAIL ignore_result_idle got=%h want=%h", bus.result, e.result); else n_pass++;
    endtask

    task automatic test_back_to_back();
        localparam int N = 12;
        logic [7:0] oa [N];
        logic [7:0] ob [N];
        logic       os [N];
        exp_t e;
        int   issued;
        int   completed;
        int   last;
        int   cyc;
        for (int i = 0; i < N; i++) begin
            oa[i] = 8'($urandom);
            ob[i] = 8'($urandom);
            os[i] = 1'($urandom);
        end
        @(negedge clk);
        drive_start(oa[0], ob[0], os[0]);
        sb_q.push_back(model(oa[0], ob[0], os[0]));
        issued    = 1;
        completed = 0;
        last      = 0;
        cyc       = 0;
        while (completed < N && cyc < N * 9 + 30) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                completed++;
                n_total++; if (cyc - last !== 9) $display("FAIL b2b%0d_interval got=%0d want=9", completed, cyc - last); else n_pass++;
                last = cyc;
                if (sb_q.size() == 0) begin
                    n_total++;
                    $display("FAIL b2b%0d_unexpected_done got=done want=none", completed);
                end else begin
                    e = sb_q.pop_front();
                    n_total++; if (bus.result !== e.result) $display("FAIL b2b%0d_result got=%h want=%h", completed, bus.result, e.result); else n_pass++;
                    n_total++; if (bus.carry_out !== e.co) $display("FAIL b2b%0d_carry got=%b want=%b", completed, bus.carry_out, e.co); else n_pass++;
                    n_total++; if (bus.overflow !== e.ov) $display("FAIL b2b%0d_ovf got=%b want=%b", completed, bus.overflow, e.ov); else n_pass++;
                end
                if (issued < N) begin
                    drive_start(oa[issued], ob[issued], os[issued]);
                    sb_q.push_back(model(oa[issued], ob[issued], os[issued]));
                    issued++;
                end else begin
                    bus.start = 1'b0;
                end
            end else begin
                // Scramble operands mid-operation; they must not be re-sampled.
                bus.a   = 8'($urandom);
                bus.b   = 8'($urandom);
                bus.sub = 1'($urandom);
            end
        end
        bus.start = 1'b0;
        n_total++; if (completed !== N) $display("FAIL b2b_completed got=%0d want=%0d", completed, N); else n_pass++;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_directed();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial two's-complement adder/subtractor. It accepts two WIDTH-bit operands and an add/subtract select on a start pulse, then processes one bit per clock, LSB first. A single registered carry flop feeds a combinational full-adder carry cell. It reports the result, carry-out and signed overflow with a one-cycle done pulse. It sits beside the combinational carry primitives as their sequential, area-minimal counterpart for datapaths where latency is cheap and gates are not.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse; result, carry_out and overflow are valid.
- result  output  WIDTH  sum/difference, held until the next accepted start.
- carry_out  output  1  final carry; for subtract, 1 = no borrow.
- overflow  output  1  signed overflow of the final bit.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE, start=1 → SHIFT: load a_sh<=a, b_sh<=(sub ? ~b : b), carry<=sub, cnt<=0, clear result.
  - SHIFT: each cycle compute s = a_sh[0]^b_sh[0]^carry and c = maj(a_sh[0], b_sh[0], carry).
    - Shift s into result MSB (result shifts right), so bit i lands at result[i] after WIDTH shifts.
    - carry<=c; shift a_sh and b_sh right; cnt<=cnt+1.
    - When cnt==WIDTH-1, latch carry_out<=c, overflow<=c^carry (carry into MSB vs carry out of MSB), → DONE.
  - DONE: done=1 for exactly this cycle. start=1 is accepted here with the same load as IDLE (→ SHIFT); otherwise → IDLE.
- start while in SHIFT is ignored. Operands and sub are not re-sampled mid-operation.
- cnt width is $clog2(WIDTH). No arithmetic wider than WIDTH except the 1-bit carry.
- Reset, including mid-operation: state=IDLE. busy, done, result, carry_out, overflow, cnt, carry and the shift registers are all 0. The in-flight operation is discarded with no done pulse.

## Timing
- Start accepted at edge T0. SHIFT occupies the cycles after T0..T(WIDTH-1). busy is high exactly WIDTH cycles.
- done is high in the cycle after edge T(WIDTH), so latency is WIDTH+1 cycles from accepting edge to done.
- result, carry_out and overflow update only at the final SHIFT edge and stay stable through DONE and IDLE until the next accepted start clears result.
- Back-to-back: start held high gives one operation every WIDTH+1 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package serial_arith_pkg holds:
  - the state enum (IDLE, SHIFT, DONE);
  - a localparam function for the counter width.
- Sub-module carry_cell: purely combinational, inputs (ci, x, y), outputs (s, co).
  - co is the majority function; s is the 3-input XOR.
  - Shareable with other serial arithmetic blocks.
- Top level holds the FSM, shift registers, carry flop and output registers.

## Test plan
All cases use WIDTH=8.
- a=0xFF, b=0x01, sub=0 → done 9 cycles after start, result=0x00, carry_out=1, overflow=0.
- a=0x7F, b=0x01, sub=0 → result=0x80, carry_out=0, overflow=1.
- a=0x05, b=0x07, sub=1 → result=0xFE, carry_out=0 (borrow), overflow=0.
- a=0x80, b=0x01, sub=1 → result=0x7F, carry_out=1, overflow=1.
- Start 0x10+0x20, pulse start again during SHIFT with a=0xAA → the second start is ignored; result=0x30, single done pulse.
- Assert rst at SHIFT cycle 4 → all outputs 0 immediately, no done pulse. Then start 0x03+0x04 → result=0x07 with normal latency.
- Random back-to-back with start held high → done every 9 cycles, each result matches a reference model.
